// File: rtl/flash_bpi_ctrl.sv
// flash_bpi_ctrl
// Sequencer for a 16-bit asynchronous parallel NOR (BPI) flash. Converts
// single-word read/write requests into flash bus cycles with parameterised
// setup, pulse, hold and turnaround timing. Read data comes back on a
// valid/ready response channel. The flash_io_dq tristate buffer lives in the
// top level; this block only drives flash_dq_o/flash_dq_oe and reads
// flash_dq_i.
//
// Ports:
//   CLK, RST              clock (rising edge), synchronous active-high reset
//   req_valid/req_ready   request handshake
//   req_write             1 = write, 0 = read
//   req_addr, req_wdata   flash word address and write data
//   rsp_valid/rsp_ready   read response handshake
//   rsp_data, rsp_err     read data; rsp_err = read ended by WAIT timeout
//   flash_addr            flash address pins (registered)
//   flash_dq_o/oe, dq_i   data bus towards/from the external tristate buffer
//   flash_wait            flash WAIT pin (asynchronous, synchronized here)
//   flash_ce_n/oe_n/we_n  active-low strobes (registered)

module flash_bpi_ctrl #(
    parameter int RD_WAIT      = 8,
    parameter int WR_SETUP     = 2,
    parameter int WR_PULSE     = 6,
    parameter int WR_HOLD      = 2,
    parameter int TURN_CYC     = 2,
    parameter int WAIT_TIMEOUT = 64
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [23:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_data,
    output logic        rsp_err,
    output logic [23:0] flash_addr,
    output logic [15:0] flash_dq_o,
    output logic        flash_dq_oe,
    input  logic [15:0] flash_dq_i,
    input  logic        flash_wait,
    output logic        flash_ce_n,
    output logic        flash_oe_n,
    output logic        flash_we_n
);

    typedef enum logic [2:0] {
        IDLE,
        RD_ACT,
        RD_EXT,
        WR_SET,
        WR_PUL,
        WR_HLD,
        TURN
    } state_t;

    // Counters count down to zero, so each phase loads its length minus one.
    localparam logic [7:0] RD_LOAD   = 8'(RD_WAIT - 1);
    localparam logic [7:0] SET_LOAD  = 8'(WR_SETUP - 1);
    localparam logic [7:0] PUL_LOAD  = 8'(WR_PULSE - 1);
    localparam logic [7:0] HLD_LOAD  = 8'(WR_HOLD - 1);
    localparam logic [7:0] TURN_LOAD = 8'(TURN_CYC - 1);
    localparam logic [7:0] TO_LOAD   = 8'(WAIT_TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [23:0] addr_q, addr_d;
    logic [15:0] dq_o_q, dq_o_d;
    logic        dq_oe_q, dq_oe_d;
    logic        ce_n_q, ce_n_d;
    logic        oe_n_q, oe_n_d;
    logic        we_n_q, we_n_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [15:0] rsp_data_q, rsp_data_d;
    logic        rsp_err_q, rsp_err_d;
    logic        wait_s1_q, wait_s2_q;
    logic        cnt_zero;
    logic        finish_rd;
    logic        rd_err;

    // Ready never looks at req_valid; the pending-response term keeps a new
    // accept from ever sharing an edge with a response clear.
    assign req_ready = (state_q == IDLE) && !rsp_valid_q && !RST;
    assign cnt_zero  = (cnt_q == 8'd0);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        dq_o_d      = dq_o_q;
        dq_oe_d     = dq_oe_q;
        ce_n_d      = ce_n_q;
        oe_n_d      = oe_n_q;
        we_n_d      = we_n_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        finish_rd   = 1'b0;
        rd_err      = 1'b0;

        if (rsp_valid_q && rsp_ready) begin
            rsp_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    addr_d = req_addr;
                    ce_n_d = 1'b0;
                    if (req_write) begin
                        state_d = WR_SET;
                        dq_o_d  = req_wdata;
                        dq_oe_d = 1'b1;
                        cnt_d   = SET_LOAD;
                    end else begin
                        state_d = RD_ACT;
                        oe_n_d  = 1'b0;
                        cnt_d   = RD_LOAD;
                    end
                end
            end
            RD_ACT: begin
                if (cnt_zero) begin
                    if (wait_s2_q) begin
                        state_d = RD_EXT;
                        cnt_d   = TO_LOAD;
                    end else begin
                        finish_rd = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            RD_EXT: begin
                // A released WAIT wins over a timeout landing on the same cycle.
                if (!wait_s2_q) begin
                    finish_rd = 1'b1;
                end else if (cnt_zero) begin
                    finish_rd = 1'b1;
                    rd_err    = 1'b1;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            WR_SET: begin
                if (cnt_zero) begin
                    state_d = WR_PUL;
                    we_n_d  = 1'b0;
                    cnt_d   = PUL_LOAD;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            WR_PUL: begin
                if (cnt_zero) begin
                    state_d = WR_HLD;
                    we_n_d  = 1'b1;
                    cnt_d   = HLD_LOAD;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            WR_HLD: begin
                if (cnt_zero) begin
                    state_d = TURN;
                    ce_n_d  = 1'b1;
                    dq_oe_d = 1'b0;
                    cnt_d   = TURN_LOAD;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            TURN: begin
                if (cnt_zero) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Common read completion: sample the bus, raise the response and
        // release the strobes in the same edge.
        if (finish_rd) begin
            rsp_data_d  = flash_dq_i;
            rsp_err_d   = rd_err;
            rsp_valid_d = 1'b1;
            ce_n_d      = 1'b1;
            oe_n_d      = 1'b1;
            state_d     = TURN;
            cnt_d       = TURN_LOAD;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            cnt_q       <= 8'd0;
            addr_q      <= 24'd0;
            dq_o_q      <= 16'd0;
            dq_oe_q     <= 1'b0;
            ce_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 16'd0;
            rsp_err_q   <= 1'b0;
            wait_s1_q   <= 1'b0;
            wait_s2_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            dq_o_q      <= dq_o_d;
            dq_oe_q     <= dq_oe_d;
            ce_n_q      <= ce_n_d;
            oe_n_q      <= oe_n_d;
            we_n_q      <= we_n_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            wait_s1_q   <= flash_wait;
            wait_s2_q   <= wait_s1_q;
        end
    end

    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_err     = rsp_err_q;
    assign flash_addr  = addr_q;
    assign flash_dq_o  = dq_o_q;
    assign flash_dq_oe = dq_oe_q;
    assign flash_ce_n  = ce_n_q;
    assign flash_oe_n  = oe_n_q;
    assign flash_we_n  = we_n_q;

endmodule
